// File: rtl/img_win_ctrl.sv
// 2x2 window image controller: loads an image from ROM, applies window commands, dumps to RAM.
// Define IMG_WIN_CTRL_EXT_EN to add the RELOAD (12) and INVERT (13) commands.
module img_win_ctrl #(
  parameter  int DATA_W = 8,
  parameter  int IMG_W  = 8,
  localparam int AW     = $clog2(IMG_W * IMG_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        cmd,
  input  logic              cmd_valid,
  input  logic [DATA_W-1:0] IROM_Q,
  output logic              IROM_rd,
  output logic [AW-1:0]     IROM_A,
  output logic              IRAM_valid,
  output logic [DATA_W-1:0] IRAM_D,
  output logic [AW-1:0]     IRAM_A,
  output logic              busy,
  output logic              done
);

  localparam int N  = IMG_W * IMG_W;
  localparam int XW = $clog2(IMG_W);

  typedef enum logic [1:0] {S_LOAD, S_IDLE, S_WRITE} state_t;
  typedef enum logic [3:0] {
    C_WRITE, C_UP, C_DOWN, C_LEFT, C_RIGHT, C_MAX, C_MIN, C_AVG,
    C_CCW, C_CW, C_MIRX, C_MIRY, C_RELOAD, C_INVERT, C_RSV14, C_RSV15
  } cmd_t;

  state_t            state, state_nxt;
  logic [AW-1:0]     pos;
  logic [XW-1:0]     px, py;
  logic [DATA_W-1:0] buffer [N];
  logic              last, accept;

  assign last   = (pos == AW'(N - 1));
  assign accept = cmd_valid && (state == S_IDLE);

  // Power-of-two width makes the row-major address a plain {y, x} concatenation.
  logic [AW-1:0] a_tl, a_tr, a_bl, a_br;
  assign a_tl = {py - XW'(1), px - XW'(1)};
  assign a_tr = {py - XW'(1), px};
  assign a_bl = {py, px - XW'(1)};
  assign a_br = {py, px};

  logic [DATA_W-1:0] p_tl, p_tr, p_bl, p_br;
  assign p_tl = buffer[a_tl];
  assign p_tr = buffer[a_tr];
  assign p_bl = buffer[a_bl];
  assign p_br = buffer[a_br];

  logic [DATA_W-1:0] max_t, max_b, w_max, min_t, min_b, w_min;
  logic [DATA_W+1:0] w_sum;
  assign max_t = (p_tl > p_tr) ? p_tl : p_tr;
  assign max_b = (p_bl > p_br) ? p_bl : p_br;
  assign w_max = (max_t > max_b) ? max_t : max_b;
  assign min_t = (p_tl < p_tr) ? p_tl : p_tr;
  assign min_b = (p_bl < p_br) ? p_bl : p_br;
  assign w_min = (min_t < min_b) ? min_t : min_b;
  assign w_sum = {2'b00, p_tl} + {2'b00, p_tr} + {2'b00, p_bl} + {2'b00, p_br};

  logic              win_we;
  logic [DATA_W-1:0] n_tl, n_tr, n_bl, n_br;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    win_we = 1'b0;
    n_tl   = p_tl;
    n_tr   = p_tr;
    n_bl   = p_bl;
    n_br   = p_br;
    case (cmd)
      C_MAX:  begin win_we = 1'b1; {n_tl, n_tr, n_bl, n_br} = {4{w_max}}; end
      C_MIN:  begin win_we = 1'b1; {n_tl, n_tr, n_bl, n_br} = {4{w_min}}; end
      C_AVG:  begin win_we = 1'b1; {n_tl, n_tr, n_bl, n_br} = {4{w_sum[DATA_W+1:2]}}; end
      C_CCW:  begin win_we = 1'b1; {n_tl, n_tr, n_bl, n_br} = {p_tr, p_br, p_tl, p_bl}; end
      C_CW:   begin win_we = 1'b1; {n_tl, n_tr, n_bl, n_br} = {p_bl, p_tl, p_br, p_tr}; end
      C_MIRX: begin win_we = 1'b1; {n_tl, n_tr, n_bl, n_br} = {p_bl, p_br, p_tl, p_tr}; end
      C_MIRY: begin win_we = 1'b1; {n_tl, n_tr, n_bl, n_br} = {p_tr, p_tl, p_br, p_bl}; end
`ifdef IMG_WIN_CTRL_EXT_EN
      C_INVERT: begin win_we = 1'b1; {n_tl, n_tr, n_bl, n_br} = ~{p_tl, p_tr, p_bl, p_br}; end
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_nxt  = state;
    busy       = (state != S_IDLE);
    IROM_rd    = (state == S_LOAD);
    IROM_A     = (state == S_LOAD) ? pos : '0;
    IRAM_valid = (state == S_WRITE);
    IRAM_A     = (state == S_WRITE) ? pos : '0;
    IRAM_D     = (state == S_WRITE) ? buffer[pos] : '0;
    case (state)
      S_LOAD:  if (last) state_nxt = S_IDLE;
      S_IDLE: begin
        if (accept && cmd == C_WRITE) state_nxt = S_WRITE;
`ifdef IMG_WIN_CTRL_EXT_EN
        if (accept && cmd == C_RELOAD) state_nxt = S_LOAD;
`endif
      end
      S_WRITE: if (last) state_nxt = S_IDLE;
      default: state_nxt = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) state <= S_LOAD;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos  <= '0;
      px   <= XW'(IMG_W / 2);
      py   <= XW'(IMG_W / 2);
      done <= 1'b0;
    end else begin
      done <= (state == S_WRITE) && last;
      if (state != S_IDLE) begin
        pos <= last ? '0 : pos + AW'(1);
      end else if (accept) begin
        pos <= '0;
        case (cmd)
          C_UP:    if (py > XW'(1))         py <= py - XW'(1);
          C_DOWN:  if (py < XW'(IMG_W - 1)) py <= py + XW'(1);
          C_LEFT:  if (px > XW'(1))         px <= px - XW'(1);
          C_RIGHT: if (px < XW'(IMG_W - 1)) px <= px + XW'(1);
          default: ;
        endcase
      end
    end
  end

  // NOTE: the buffer must read as zero straight out of reset, so it is built from resettable flops rather than a RAM macro.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) buffer[i] <= '0;
    end else if (state == S_LOAD) begin
      buffer[pos] <= IROM_Q;
    end else if (accept && win_we) begin
      buffer[a_tl] <= n_tl;
      buffer[a_tr] <= n_tr;
      buffer[a_bl] <= n_bl;
      buffer[a_br] <= n_br;
    end
  end

endmodule

// File: tb/tb_img_win_ctrl.sv
// Scoreboard bench for img_win_ctrl: an array-level image model predicts ROM reads and RAM dumps.
module tb_img_win_ctrl;

  localparam int DATA_W = 8;
  localparam int IMG_W  = 8;
  localparam int N      = IMG_W * IMG_W;
  localparam int AW     = $clog2(N);

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [3:0]        cmd = 4'd0;
  logic              cmd_valid = 1'b0;
  logic [DATA_W-1:0] IROM_Q;
  logic              IROM_rd, IRAM_valid, busy, done;
  logic [AW-1:0]     IROM_A, IRAM_A;
  logic [DATA_W-1:0] IRAM_D;

  logic [DATA_W-1:0] rom [N];
  assign IROM_Q = rom[IROM_A];

  img_win_ctrl #(.DATA_W(DATA_W), .IMG_W(IMG_W)) dut (
    .clk(clk), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid), .IROM_Q(IROM_Q),
    .IROM_rd(IROM_rd), .IROM_A(IROM_A), .IRAM_valid(IRAM_valid), .IRAM_D(IRAM_D),
    .IRAM_A(IRAM_A), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {int a; int d; bit last;} beat_t;

  int    n_vec = 0;
  int    n_err = 0;
  int    img [N];
  int    px, py;
  int    rom_q [$];
  beat_t wr_q [$];
  bit    prev_last = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expected ROM addresses / RAM beats whenever the DUT presents them.
  always @(negedge clk) begin
    if (reset) begin
      prev_last = 1'b0;
    end else begin
      if (IROM_rd) begin
        if (rom_q.size() == 0) check("rom_unexpected_rd", IROM_rd, 0);
        else                   check("rom_addr", IROM_A, rom_q.pop_front());
      end else begin
        check("rom_addr_idle", IROM_A, 0);
      end
      check("done", done, prev_last);
      if (IRAM_valid) begin
        if (wr_q.size() == 0) begin
          check("ram_unexpected_wr", IRAM_valid, 0);
          prev_last = 1'b0;
        end else begin
          beat_t b;
          b = wr_q.pop_front();
          check("ram_addr", IRAM_A, b.a);
          check("ram_data", IRAM_D, b.d);
          prev_last = b.last;
        end
      end else begin
        check("ram_idle", {IRAM_A, IRAM_D}, 0);
        prev_last = 1'b0;
      end
    end
  end

  function automatic int idx(input int y, input int x);
    return y * IMG_W + x;
  endfunction

  task automatic model_load();
    for (int k = 0; k < N; k++) begin
      img[k] = int'(rom[k]);
      rom_q.push_back(k);
    end
  endtask

  // Reference model: applies one accepted command to the image array and point.
  task automatic model_cmd(input logic [3:0] c, output bit goes_busy);
    int ix [4];
    int w [4];
    int nw [4];
    int m;
    goes_busy = 1'b0;
    ix = '{idx(py - 1, px - 1), idx(py - 1, px), idx(py, px - 1), idx(py, px)};
    for (int i = 0; i < 4; i++) w[i] = img[ix[i]];
    nw = w;
    case (c)
      4'd0: begin
        goes_busy = 1'b1;
        for (int k = 0; k < N; k++) wr_q.push_back('{a: k, d: img[k], last: (k == N - 1)});
      end
      4'd1: if (py > 1) py--;
      4'd2: if (py < IMG_W - 1) py++;
      4'd3: if (px > 1) px--;
      4'd4: if (px < IMG_W - 1) px++;
      4'd5: begin
        m = w[0];
        for (int i = 1; i < 4; i++) if (w[i] > m) m = w[i];
        nw = '{m, m, m, m};
      end
      4'd6: begin
        m = w[0];
        for (int i = 1; i < 4; i++) if (w[i] < m) m = w[i];
        nw = '{m, m, m, m};
      end
      4'd7: begin
        m = (w[0] + w[1] + w[2] + w[3]) / 4;
        nw = '{m, m, m, m};
      end
      4'd8:  nw = '{w[1], w[3], w[0], w[2]};
      4'd9:  nw = '{w[2], w[0], w[3], w[1]};
      4'd10: nw = '{w[2], w[3], w[0], w[1]};
      4'd11: nw = '{w[1], w[0], w[3], w[2]};
`ifdef IMG_WIN_CTRL_EXT_EN
      4'd12: begin
        goes_busy = 1'b1;
        model_load();
      end
      4'd13: for (int i = 0; i < 4; i++) nw[i] = (2 ** DATA_W - 1) - w[i];
`endif
      default: ;
    endcase
    if (c != 4'd12) for (int i = 0; i < 4; i++) img[ix[i]] = nw[i];
  endtask

  task automatic wait_idle(input string name, input int exp_len);
    int cnt = 0;
    while (busy && cnt < N + 16) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    if (exp_len >= 0) check(name, cnt, exp_len);
    else              check(name, busy, 0);
  endtask

  // Issue one command at posedge+1; it is sampled at the following edge.
  task automatic send(input logic [3:0] c, input bit wait_done = 1'b1);
    bit bz;
    check("busy_before_cmd", busy, 0);
    cmd       = c;
    cmd_valid = 1'b1;
    model_cmd(c, bz);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd       = 4'($urandom);
    check("busy_after_cmd", busy, 32'(bz));
    if (bz && wait_done) wait_idle("busy_len", N);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    cmd_valid = 1'b0;
    rom_q.delete();
    wr_q.delete();
    prev_last = 1'b0;
    #1;
    check("rst_busy", busy, 1);
    check("rst_irom_rd", IROM_rd, 1);
    check("rst_irom_a", IROM_A, 0);
    check("rst_iram", {IRAM_valid, IRAM_A, IRAM_D}, 0);
    check("rst_done", done, 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    px = IMG_W / 2;
    py = IMG_W / 2;
    model_load();
    wait_idle("load_len", N);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < N; k++) rom[k] = DATA_W'(k);

    do_reset();
    send(4'd0);
    repeat (5) send(4'd3);
    send(4'd5);
    send(4'd0);

    do_reset();
    send(4'd7);
    send(4'd0);

    do_reset();
    send(4'd9);
    send(4'd0);
    send(4'd8);
    send(4'd0);
    send(4'd9);
    send(4'd6);
    send(4'd0);

    // Commands presented during WRITE must be dropped.
    send(4'd0, 1'b0);
    repeat (10) begin @(posedge clk); #1; end
    cmd = 4'd5;
    cmd_valid = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("busy_in_write", busy, 1);
    end
    cmd_valid = 1'b0;
    wait_idle("write_tail_len", N - 13);
    send(4'd0);

    // Reset while IRAM_A=20 is on the bus: no done, LOAD from address 0.
    send(4'd0, 1'b0);
    for (int g = 0; g < 200 && wr_q.size() != 44; g++) begin @(posedge clk); #2; end
    check("sync_write20", wr_q.size(), 44);
    @(negedge clk);
    #1;
    do_reset();
    send(4'd0);

`ifdef IMG_WIN_CTRL_EXT_EN
    send(4'd13);
    send(4'd0);
    send(4'd12);
    send(4'd0);
`else
    send(4'd12);
    send(4'd13);
    send(4'd0);
`endif

    // Randomized phase: random ROM image, a reset aborting LOAD, then random command stream.
    for (int k = 0; k < N; k++) rom[k] = DATA_W'($urandom);
    reset = 1'b1;
    rom_q.delete();
    wr_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_load();
    repeat (10) begin @(posedge clk); #1; end
    do_reset();
    for (int i = 0; i < 200; i++) begin
      logic [3:0] c;
      c = 4'($urandom_range(0, 15));
      if (c == 4'd0 && $urandom_range(0, 3) != 0) c = 4'($urandom_range(1, 4));
      send(c);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
    end
    send(4'd0);
    repeat (3) begin @(posedge clk); #1; end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/img_win_ctrl.md
IMG_WIN_CTRL -- requirements
Module: img_win_ctrl

Interface
REQ-001 Parameter DATA_W, default 8, pixel width in bits (4..16).
REQ-002 Parameter IMG_W, default 8, image side length in pixels; power of two, 4..16; N = IMG_W*IMG_W, AW = log2(N).
REQ-003 clk  input  1  clock, all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 cmd  input  4  command code, sampled when cmd_valid=1 and busy=0.
REQ-006 cmd_valid  input  1  command qualifier.
REQ-007 IROM_Q  input  DATA_W  ROM read data, asynchronous read of IROM_A.
REQ-008 IROM_rd  output  1  ROM read enable.
REQ-009 IROM_A  output  AW  ROM address.
REQ-010 IRAM_valid  output  1  RAM write strobe.
REQ-011 IRAM_D  output  DATA_W  RAM write data.
REQ-012 IRAM_A  output  AW  RAM write address.
REQ-013 busy  output  1  high while in LOAD or WRITE; commands ignored.
REQ-014 done  output  1  single-cycle pulse after the last RAM write.

Function
REQ-015 Internal image buffer of N pixels, row-major, address = y*IMG_W + x; operation point (x,y) each in [1, IMG_W-1] selects window TL=(y-1,x-1), TR=(y-1,x), BL=(y,x-1), BR=(y,x).
REQ-016 States: LOAD, IDLE, WRITE; busy = (state != IDLE), combinational.
REQ-017 LOAD: IROM_rd=1, IROM_A=pos; each cycle buffer[pos] <= IROM_Q, pos++; after pos=N-1 go IDLE, pos <= 0; duration exactly N cycles.
REQ-018 IDLE with cmd_valid=1: cmd 0 WRITE -> WRITE, pos <= 0; all other commands complete in one cycle, result visible the following cycle, busy stays 0.
REQ-019 cmd 1/2/3/4 shift up/down/left/right by one; saturate at 1 (up/left) and IMG_W-1 (down/right); no wrap.
REQ-020 cmd 5 MAX / 6 MIN: all four window pixels <= max/min of the four (unsigned).
REQ-021 cmd 7 AVG: all four <= floor(sum/4), sum computed at DATA_W+2 bits, no overflow.
REQ-022 cmd 8 rotate CCW: TL<=TR, TR<=BR, BL<=TL, BR<=BL; cmd 9 rotate CW: TL<=BL, TR<=TL, BL<=BR, BR<=TR.
REQ-023 cmd 10 mirror X (swap rows): TL<=BL, TR<=BR, BL<=TL, BR<=TR; cmd 11 mirror Y (swap columns): TL<=TR, TR<=TL, BL<=BR, BR<=BL.
REQ-024 cmd 12..15 without REQ-034 features: no operation, state unchanged.
REQ-025 WRITE: IRAM_valid=1, IRAM_A=pos, IRAM_D=buffer[pos]; pos++ each cycle; after pos=N-1 go IDLE and assert done for exactly the next cycle.
REQ-026 Outside WRITE: IRAM_valid=0, IRAM_D=0, IRAM_A=0; outside LOAD: IROM_rd=0, IROM_A=0.
REQ-027 cmd_valid while busy=1 is dropped, not queued; no command can modify the buffer during LOAD or WRITE.
REQ-028 Operation point and buffer are unchanged by WRITE; consecutive commands on back-to-back cycles are each applied.

Reset
REQ-029 reset asserted: state=LOAD, pos=0, point=(IMG_W/2, IMG_W/2), buffer cleared to 0, done=0.
REQ-030 Outputs during reset: busy=1, IROM_rd=1, IROM_A=0, IRAM_valid=0, IRAM_D=0, IRAM_A=0, done=0.
REQ-031 Reset mid-LOAD or mid-WRITE aborts immediately; LOAD restarts at address 0; no done pulse for the aborted WRITE.

Configuration
REQ-032 Macro IMG_WIN_CTRL_EXT_EN compiles in extended commands.
REQ-033 Defined: cmd 12 RELOAD -> LOAD (pos<=0, point unchanged, busy=1, N cycles); cmd 13 INVERT -> four window pixels <= (2^DATA_W-1) - pixel, one cycle.
REQ-034 Undefined: cmd 12 and 13 are no-ops per REQ-024; no reload logic synthesised.

Verification (IMG_W=8, DATA_W=8, ROM[k]=k)
REQ-035 Reset release -> busy=1 for 64 cycles with IROM_A 0..63, then busy=0; WRITE -> IRAM_A/IRAM_D 0..63 for 64 cycles, done=1 one cycle after IRAM_A=63.
REQ-036 Five shift-left from (4,4) -> x=1; MAX -> RAM addrs 24,25,32,33 all read 33 on WRITE.
REQ-037 AVG at (4,4) -> addrs 27,28,35,36 all = 31 (sum 126); MIN at (4,4) after CW -> all four = 27.
REQ-038 CW at (4,4) -> addr27=35, addr28=27, addr35=36, addr36=28; then CCW -> original 27,28,35,36 restored.
REQ-039 cmd_valid=1 cmd=5 during WRITE -> ignored, dump unchanged; reset at IRAM_A=20 -> LOAD from 0, no done.
REQ-040 With IMG_WIN_CTRL_EXT_EN: INVERT at (4,4) then RELOAD -> busy 64 cycles, addr27 back to 27; without macro cmd 12 -> busy stays 0, buffer unchanged.
